// File: rtl/ace_ccu_snoop_resp_if.sv
// ace_ccu_snoop_resp_if: ctrl, snooped-master CR and initiator CR channels of the snoop-response collector.
interface ace_ccu_snoop_resp_if #(
    parameter int NumInp = 4,
    parameter int NumOup = 4,
    parameter int IdxW   = (NumInp > 1) ? $clog2(NumInp) : 1
);
    logic                     ctrl_valid;
    logic                     ctrl_ready;
    logic [NumOup+IdxW-1:0]   ctrl;
    logic [NumOup-1:0]        snp_valids;
    logic [NumOup-1:0]        snp_readies;
    logic [NumOup*5-1:0]      snp_resps;
    logic [NumInp-1:0]        cr_valids;
    logic [NumInp-1:0]        cr_readies;
    logic [4:0]               cr_resp;

    modport slave (
        input  ctrl_valid, ctrl, snp_valids, snp_resps, cr_readies,
        output ctrl_ready, snp_readies, cr_valids, cr_resp
    );

    modport master (
        output ctrl_valid, ctrl, snp_valids, snp_resps, cr_readies,
        input  ctrl_ready, snp_readies, cr_valids, cr_resp
    );
endinterface

// File: rtl/ace_ccu_snoop_resp.sv
// ace_ccu_snoop_resp: queues snoop ctrl entries in order, collects and OR-merges the selected
// masters' CRs, and returns one merged CR to the initiating port.
module ace_ccu_snoop_resp #(
    parameter int NumInp    = 4,
    parameter int NumOup    = 4,
    parameter int CtrlDepth = 4,
    parameter int IdxW      = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ace_ccu_snoop_resp_if.slave  bus
);
    localparam int PtrW = $clog2(CtrlDepth);
    localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, RESP = 2'd2;

    logic [NumOup+IdxW-1:0] mem [CtrlDepth];
    logic [PtrW-1:0]        wptr, rptr;
    logic [PtrW:0]          cnt;
    logic [1:0]             state, state_next;
    logic [NumOup-1:0]      got, acc, sel;
    logic [IdxW-1:0]        idx;
    logic [4:0]             merge, merge_acc;
    logic                   push, pop, full;

    assign full            = cnt == (PtrW+1)'(CtrlDepth);
    assign bus.ctrl_ready  = !full;
    assign push            = bus.ctrl_valid && !full;
    assign {sel, idx}      = mem[rptr];
    assign bus.snp_readies = (state == COLLECT) ? sel & ~got : '0;
    assign acc             = bus.snp_valids & bus.snp_readies;
    assign bus.cr_valids   = (state == RESP) ? NumInp'(1) << idx : '0;
    assign bus.cr_resp     = merge;
    assign pop             = (state == RESP) && ((bus.cr_valids & bus.cr_readies) != '0);

    always_comb begin
        merge_acc = merge;
        for (int j = 0; j < NumOup; j++)
            merge_acc = acc[j] ? merge_acc | bus.snp_resps[5*j +: 5] : merge_acc;
    end

    // A pop with an entry pushed in the same cycle still leaves work at the head.
    always_comb begin
        state_next = IDLE;
        unique case (state)
            IDLE:    state_next = (cnt != '0) ? COLLECT : IDLE;
            COLLECT: state_next = (((got | acc) & sel) == sel) ? RESP : COLLECT;
            RESP:    state_next = !pop ? RESP : (cnt > (PtrW+1)'(1) || push) ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i)
        if (push) mem[wptr] <= bus.ctrl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            state <= IDLE;
            got   <= '0;
            merge <= '0;
        end else begin
            wptr  <= push ? wptr + PtrW'(1) : wptr;
            rptr  <= pop ? rptr + PtrW'(1) : rptr;
            cnt   <= cnt + (PtrW+1)'(push) - (PtrW+1)'(pop);
            state <= state_next;
            got   <= pop ? '0 : got | acc;
            merge <= pop ? '0 : merge_acc;
        end
    end
endmodule

// File: tb/tb_ace_ccu_snoop_resp.sv
// tb_ace_ccu_snoop_resp: directed literal scenarios plus randomized traffic checked against a
// transaction-level model (per-master CR queues, in-order snoop list, OR-merged expectations).
module tb_ace_ccu_snoop_resp;
    localparam int NI = 4, NO = 4, D = 4, IW = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    ace_ccu_snoop_resp_if #(.NumInp(NI), .NumOup(NO), .IdxW(IW)) b ();
    ace_ccu_snoop_resp #(.NumInp(NI), .NumOup(NO), .CtrlDepth(D)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (b)
    );

    typedef struct {int id; logic [IW-1:0] idx; logic [NO-1:0] sel; logic [4:0] exp; int rem; int last;} txn_t;
    typedef struct {int id; logic [4:0] r;} cr_t;

    txn_t txq[$];
    cr_t  mq[NO][$];
    int   tests = 0, fails = 0, cyc = 0, nid = 0;
    bit   hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic clear_in();
        b.ctrl_valid = 1'b0;
        b.ctrl       = '0;
        b.snp_valids = '0;
        b.snp_resps  = '0;
        b.cr_readies = '0;
    endtask

    task automatic clear_model();
        txq.delete();
        for (int j = 0; j < NO; j++) mq[j].delete();
        hold = 1'b0;
    endtask

    task automatic push(input logic [NO-1:0] sel, input logic [IW-1:0] idx);
        b.ctrl_valid = 1'b1;
        b.ctrl       = {sel, idx};
        step();
        b.ctrl_valid = 1'b0;
    endtask

    // One randomized cycle: check outputs against the model, drive, then account for the edge.
    task automatic cycle_rand(input bit gen);
        bit popped;
        chk("ctrl_ready", 32'(b.ctrl_ready), 32'(txq.size() < D));
        if (b.cr_valids != '0 || hold ||
            (txq.size() > 0 && txq[0].sel != '0 && txq[0].rem == 0 && txq[0].last == cyc - 1)) begin
            if (txq.size() == 0)
                chk("resp without snoop", 32'(b.cr_valids), 32'(0));
            else begin
                chk("resp valid", 32'(b.cr_valids), txq[0].rem == 0 ? 32'(NI'(1) << txq[0].idx) : 32'(0));
                if (b.cr_valids != '0) begin
                    chk("resp data", 32'(b.cr_resp), 32'(txq[0].exp));
                    chk("cr ready during resp", 32'(b.snp_readies), 32'(0));
                end
            end
        end
        b.ctrl_valid = gen && ($urandom_range(0, 2) == 0);
        b.ctrl       = {NO'($urandom), IW'($urandom)};
        for (int j = 0; j < NO; j++) begin
            if (mq[j].size() > 0) begin
                if (!b.snp_valids[j]) b.snp_valids[j] = 1'($urandom_range(0, 1));
                b.snp_resps[5*j +: 5] = mq[j][0].r;
            end else begin
                b.snp_valids[j]       = 1'b0;
                b.snp_resps[5*j +: 5] = 5'($urandom);
            end
        end
        b.cr_readies = gen ? NI'($urandom) : '1;
        #1;
        popped = (b.cr_valids & b.cr_readies) != '0;
        for (int j = 0; j < NO; j++) begin
            if (b.snp_valids[j] && b.snp_readies[j]) begin
                if (mq[j].size() == 0 || txq.size() == 0)
                    chk("cr accepted with nothing pending", 32'(mq[j].size() > 0 && txq.size() > 0), 32'(1));
                else begin
                    chk("cr order", 32'(mq[j][0].id), 32'(txq[0].id));
                    txq[0].rem  = txq[0].rem - 1;
                    txq[0].last = cyc;
                    void'(mq[j].pop_front());
                end
            end
        end
        if (popped && txq.size() > 0) void'(txq.pop_front());
        hold = (b.cr_valids != '0) && !popped;
        if (b.ctrl_valid && b.ctrl_ready) begin
            txn_t t;
            t.id   = nid++;
            t.sel  = b.ctrl[NO+IW-1:IW];
            t.idx  = b.ctrl[IW-1:0];
            t.exp  = '0;
            t.rem  = 0;
            t.last = -10;
            for (int j = 0; j < NO; j++) begin
                if (t.sel[j]) begin
                    cr_t c;
                    c.id  = t.id;
                    c.r   = 5'($urandom);
                    t.exp = t.exp | c.r;
                    t.rem++;
                    mq[j].push_back(c);
                end
            end
            txq.push_back(t);
        end
        step();
    endtask

    initial begin
        clear_in();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        chk("reset cr_valids", 32'(b.cr_valids), 32'(0));
        chk("reset snp_readies", 32'(b.snp_readies), 32'(0));
        chk("reset ctrl_ready", 32'(b.ctrl_ready), 32'(1));
        chk("reset cr_resp", 32'(b.cr_resp), 32'(0));

        // single snoop, CRs three cycles apart
        push(4'b0110, 2'd2);
        step();
        chk("t2 readies", 32'(b.snp_readies), 32'(4'b0110));
        b.snp_valids = 4'b0010; b.snp_resps[5 +: 5] = 5'b00010;
        step();
        chk("t2 readies after cr1", 32'(b.snp_readies), 32'(4'b0100));
        b.snp_valids = '0;
        step(); step();
        chk("t2 no early resp", 32'(b.cr_valids), 32'(0));
        b.snp_valids = 4'b0100; b.snp_resps[10 +: 5] = 5'b01000;
        step();
        chk("t2 cr_valids", 32'(b.cr_valids), 32'(4'b0100));
        chk("t2 cr_resp", 32'(b.cr_resp), 32'(5'b01010));
        chk("t2 readies in resp", 32'(b.snp_readies), 32'(0));
        b.snp_valids = '0;
        step();
        chk("t2 held", 32'(b.cr_valids), 32'(4'b0100));
        b.cr_readies = 4'b1011;
        step();
        chk("t2 other readies ignored", 32'(b.cr_valids), 32'(4'b0100));
        b.cr_readies = 4'b0100;
        step();
        b.cr_readies = '0;
        chk("t2 popped", 32'(b.cr_valids), 32'(0));

        // all four CRs in one cycle
        push(4'b1111, 2'd1);
        step();
        chk("t3 readies", 32'(b.snp_readies), 32'(4'b1111));
        b.snp_valids = 4'hf; b.snp_resps = {5'd8, 5'd4, 5'd2, 5'd1};
        step();
        chk("t3 cr_valids", 32'(b.cr_valids), 32'(4'b0010));
        chk("t3 cr_resp", 32'(b.cr_resp), 32'(5'b01111));
        b.snp_valids = '0; b.cr_readies = 4'b0010;
        step();
        b.cr_readies = '0;
        chk("t3 popped", 32'(b.cr_valids), 32'(0));

        // empty select
        push(4'b0000, 2'd0);
        chk("t4 not yet", 32'(b.cr_valids), 32'(0));
        step();
        chk("t4 not yet 2", 32'(b.cr_valids), 32'(0));
        step();
        chk("t4 cr_valids", 32'(b.cr_valids), 32'(4'b0001));
        chk("t4 cr_resp", 32'(b.cr_resp), 32'(0));
        b.cr_readies = 4'b0001;
        step();
        b.cr_readies = '0;

        // ordering and back-pressure
        b.snp_valids = 4'b0001; b.snp_resps[0 +: 5] = 5'b00100;
        b.ctrl_valid = 1'b1; b.ctrl = {4'b0001, 2'd1};
        step();
        b.ctrl = {4'b0001, 2'd3};
        step();
        b.ctrl_valid = 1'b0;
        chk("t5 collect A", 32'(b.snp_readies), 32'(4'b0001));
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t5 resp A held", 32'(b.cr_valids), 32'(4'b0010));
            chk("t5 master0 blocked", 32'(b.snp_readies), 32'(0));
            step();
        end
        b.cr_readies = 4'b0010;
        step();
        b.cr_readies = '0;
        chk("t5 A popped", 32'(b.cr_valids), 32'(0));
        chk("t5 collect B", 32'(b.snp_readies), 32'(4'b0001));
        step();
        chk("t5 resp B", 32'(b.cr_valids), 32'(4'b1000));
        chk("t5 resp B data", 32'(b.cr_resp), 32'(5'b00100));
        b.snp_valids = '0; b.cr_readies = 4'b1000;
        step();
        b.cr_readies = '0;
        chk("t5 B popped", 32'(b.cr_valids), 32'(0));

        // fill the ctrl FIFO
        b.ctrl_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b.ctrl = {4'b0001, 2'(i)};
            step();
        end
        chk("t6 full", 32'(b.ctrl_ready), 32'(0));
        b.ctrl = {4'b0010, 2'd3};
        step();
        chk("t6 fifth held", 32'(b.ctrl_ready), 32'(0));
        b.snp_valids = 4'b0001; b.snp_resps[0 +: 5] = 5'b10000;
        step();
        chk("t6 first resp", 32'(b.cr_valids), 32'(4'b0001));
        chk("t6 first resp data", 32'(b.cr_resp), 32'(5'b10000));
        b.snp_valids = '0; b.cr_readies = 4'b0001;
        step();
        b.cr_readies = '0;
        chk("t6 ready after pop", 32'(b.ctrl_ready), 32'(1));
        step();
        chk("t6 full again", 32'(b.ctrl_ready), 32'(0));
        b.ctrl_valid = 1'b0;

        // reset in the middle of collecting
        chk("t1 collecting", 32'(b.snp_readies), 32'(4'b0001));
        rst_i = 1'b1;
        #1;
        chk("t1 cr_valids", 32'(b.cr_valids), 32'(0));
        chk("t1 snp_readies", 32'(b.snp_readies), 32'(0));
        chk("t1 ctrl_ready", 32'(b.ctrl_ready), 32'(1));
        step();
        rst_i = 1'b0;
        b.snp_valids = 4'hf;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1 old never answered", 32'(b.cr_valids), 32'(0));
            chk("t1 no cr accepted", 32'(b.snp_readies), 32'(0));
        end
        clear_in();
        clear_model();
        step();

        // randomized traffic against the model, then drain
        for (int i = 0; i < 3000; i++) cycle_rand(1'b1);
        for (int i = 0; i < 400 && txq.size() > 0; i++) cycle_rand(1'b0);
        chk("drain empty", 32'(txq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
